// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit 7-segment scan display.
// Font is active low, bit6=a ... bit0=g.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    typedef logic [1:0] digit_t;
    typedef logic [3:0] nibble_t;
    typedef logic [6:0] seg_t;

    // Entry k is the pattern for hex digit k.
    localparam logic [15:0][6:0] SEG7_FONT = {
        7'h38, 7'h30, 7'h42, 7'h31,
        7'h60, 7'h08, 7'h04, 7'h00,
        7'h0F, 7'h20, 7'h24, 7'h4C,
        7'h06, 7'h12, 7'h4F, 7'h01
    };

    // True when nibbles k..3 are all zero.
    function automatic logic [3:0] zero_above(
        input logic [15:0] v
    );
        logic [3:0] z;
        z[3] = (v[15:12] == 4'h0);
        z[2] = z[3] && (v[11:8] == 4'h0);
        z[1] = z[2] && (v[7:4] == 4'h0);
        z[0] = z[1] && (v[3:0] == 4'h0);
        return z;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Hex nibble to active-low 7-segment pattern.
// Purely combinational lookup into the shared font.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Font lookup.
    always_comb begin
        seg = SEG7_FONT[nibble];
    end

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed 4-digit common-anode 7-segment driver.
// Input is snapshotted once per frame so digits never tear.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 2000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [15:0] data,
    input  logic [3:0]  dp_in,
    input  logic        lzb,
    output logic [6:0]  a_to_g,
    output logic [3:0]  an,
    output logic        dp
);

    localparam int CW = $clog2(SCAN_DIV);

    localparam logic [CW-1:0] CNT_MAX =
        CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK =
        CW'(BLANK_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    digit_t        digit_q, digit_d;
    logic [15:0]   data_q, data_d;
    logic [3:0]    dp_q, dp_d;
    seg_t          seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          dpo_q, dpo_d;

    logic    tick;
    logic    frame_end;
    nibble_t nib;
    seg_t    font_seg;
    logic    blanked;
    logic    lit;
    logic [3:0] blank_mask;
    logic [3:0] an_sel;

    hex_to_seg7 u_font (
        .nibble (nib),
        .seg    (font_seg)
    );

    // Prescaler, digit index and frame snapshot.
    always_comb begin
        tick      = (cnt_q == CNT_MAX);
        frame_end = tick && (digit_q == 2'd3);
        cnt_d     = tick ? '0 : cnt_q + 1'b1;
        digit_d   = tick ? digit_q + 2'd1 : digit_q;
        data_d    = frame_end ? data : data_q;
        dp_d      = frame_end ? dp_in : dp_q;
    end

    // Blanking and next output values for the current slot.
    always_comb begin
        nib        = data_q[digit_q*4 +: 4];
        blank_mask = zero_above(data_q)
                   & {3'b111, 1'b0}
                   & {4{lzb}};
        blanked    = blank_mask[digit_q];
        lit        = (cnt_q >= CNT_BLANK) && !blanked;
        an_sel     = 4'b0001 << digit_q;
        an_d       = lit ? ~an_sel : AN_OFF;
        seg_d      = blanked ? SEG_OFF : font_seg;
        dpo_d      = lit ? ~dp_q[digit_q] : 1'b1;
    end

    // State and output registers; reset darkens the display at once.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q   <= '0;
            digit_q <= '0;
            data_q  <= '0;
            dp_q    <= '0;
            seg_q   <= SEG_OFF;
            an_q    <= AN_OFF;
            dpo_q   <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
            data_q  <= data_d;
            dp_q    <= dp_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            dpo_q   <= dpo_d;
        end
    end

    assign a_to_g = seg_q;
    assign an     = an_q;
    assign dp     = dpo_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display with a per-cycle
// scoreboard plus literal spot checks.
module tb_seg7_scan_display;

    localparam int SD = 8;
    localparam int BC = 2;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] data = 16'h0000;
    logic [3:0]  dp_in = 4'b0000;
    logic        lzb = 1'b0;
    logic [6:0]  a_to_g;
    logic [3:0]  an;
    logic        dp;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    int          m_cnt = 0;
    int          m_dig = 0;
    logic [15:0] m_data = 16'h0;
    logic [3:0]  m_dp = 4'h0;

    logic [6:0] font [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06,
        7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60,
        7'h31, 7'h42, 7'h30, 7'h38
    };

    seg7_scan_display #(
        .SCAN_DIV     (SD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .data   (data),
        .dp_in  (dp_in),
        .lzb    (lzb),
        .a_to_g (a_to_g),
        .an     (an),
        .dp     (dp)
    );

    always #5 clock = ~clock;

    function automatic exp_t model_out();
        exp_t       e;
        logic       blank;
        logic       lit;
        logic [3:0] onehot;
        logic [15:0] hi;
        hi     = m_data >> (4 * m_dig);
        blank  = (m_dig != 0) && lzb && (hi == 16'h0);
        lit    = (m_cnt >= BC) && !blank;
        onehot = 4'b0001 << m_dig;
        e.an   = lit ? ~onehot : 4'hF;
        e.seg  = blank ? 7'h7F : font[m_data[4*m_dig +: 4]];
        e.dp   = lit ? ~m_dp[m_dig] : 1'b1;
        return e;
    endfunction

    task automatic step();
        exp_t e;
        exp_t g;
        @(posedge clock);
        if (!resetn) begin
            m_cnt  = 0;
            m_dig  = 0;
            m_data = 16'h0;
            m_dp   = 4'h0;
            q.push_back({4'hF, 7'h7F, 1'b1});
        end else begin
            q.push_back(model_out());
            if (m_cnt == SD - 1) begin
                if (m_dig == 3) begin
                    m_data = data;
                    m_dp   = dp_in;
                end
                m_dig = (m_dig + 1) % 4;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
        @(negedge clock);
        e = q.pop_front();
        g = {an, a_to_g, dp};
        checks++;
        assert (g === e) else begin
            errors++;
            $error("FAIL sb an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                   an, a_to_g, dp, e.an, e.seg, e.dp);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic dchk(input string tag,
                        input logic [3:0] x_an,
                        input logic [6:0] x_seg,
                        input logic x_dp);
        checks++;
        assert ({an, a_to_g, dp} === {x_an, x_seg, x_dp}) else begin
            errors++;
            $error("FAIL %s got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                   tag, an, a_to_g, dp, x_an, x_seg, x_dp);
        end
    endtask

    initial begin
        // 1: reset, then release
        run(3);
        dchk("rst_dark", 4'hF, 7'h7F, 1'b1);
        resetn = 1'b1;
        run(2);
        dchk("rel_blank", 4'hF, 7'h01, 1'b1);
        run(1);
        dchk("rel_d0", 4'b1110, 7'h01, 1'b1);

        // 2: free-running slot order
        run(8);
        dchk("slot1", 4'b1101, 7'h01, 1'b1);
        run(8);
        dchk("slot2", 4'b1011, 7'h01, 1'b1);
        run(8);
        dchk("slot3", 4'b0111, 7'h01, 1'b1);
        run(8);
        dchk("slot0", 4'b1110, 7'h01, 1'b1);

        // 3: new data in digit 1 waits for frame wrap
        run(8);
        data = 16'h1234;
        run(8);
        dchk("hold_d2", 4'b1011, 7'h01, 1'b1);
        run(8);
        dchk("hold_d3", 4'b0111, 7'h01, 1'b1);
        run(8);
        dchk("new_d0", 4'b1110, 7'h4C, 1'b1);
        run(8);
        dchk("new_d1", 4'b1101, 7'h06, 1'b1);
        run(8);
        dchk("new_d2", 4'b1011, 7'h12, 1'b1);
        run(8);
        dchk("new_d3", 4'b0111, 7'h4F, 1'b1);

        // 4: leading-zero blanking
        lzb  = 1'b1;
        data = 16'h00A0;
        run(8);
        dchk("lzb_d0", 4'b1110, 7'h01, 1'b1);
        run(8);
        dchk("lzb_d1", 4'b1101, 7'h08, 1'b1);
        run(8);
        dchk("lzb_d2", 4'hF, 7'h7F, 1'b1);
        run(8);
        dchk("lzb_d3", 4'hF, 7'h7F, 1'b1);

        // 5: decimal point on digit 2
        lzb   = 1'b0;
        dp_in = 4'b0100;
        run(8);
        dchk("dp_d0", 4'b1110, 7'h01, 1'b1);
        run(8);
        dchk("dp_d1", 4'b1101, 7'h08, 1'b1);
        run(7);
        dchk("dp_d2_dark", 4'hF, 7'h01, 1'b1);
        run(1);
        dchk("dp_d2_lit", 4'b1011, 7'h01, 1'b0);
        run(2);

        // 6: async reset mid digit-2 slot
        #1 resetn = 1'b0;
        #1;
        dchk("async_rst", 4'hF, 7'h7F, 1'b1);
        run(2);
        resetn = 1'b1;
        run(2);
        dchk("rst2_blank", 4'hF, 7'h01, 1'b1);
        run(1);
        dchk("rst2_d0", 4'b1110, 7'h01, 1'b1);
        run(8);
        dchk("rst2_d1", 4'b1101, 7'h01, 1'b1);
        run(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
